// File: rtl/decim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decim_pkg
// Purpose  : Shared types, constants and helpers for the multi-channel
//            decimating-FIR sequencer and its pipeline stages.
// Contents : decim_state_t       - sequencer state encoding (IDLE, RUN)
//            DecimDefaultMacLat  - default read-to-MAC pipeline depth
//            decim_addr_wrap()   - (base - tap) mod 2^aw
// Revision : 1.0 - initial release
// ============================================================================
package decim_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } decim_state_t;

    localparam int DecimDefaultMacLat = 2;

    // Circular-buffer read address: walks backwards from the newest sample.
    function automatic logic [31:0] decim_addr_wrap(
        input logic [31:0] base,
        input logic [31:0] tap,
        input int unsigned aw
    );
        logic [31:0] w_mask;
        w_mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
        return (base - tap) & w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decim_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : decim_delay_line
// Purpose  : Width/depth parametrised shift register used to align control
//            pulses with the memory/MAC pipeline. DEPTH==0 is a wire.
// Ports    : Clk_i   - clock
//            Rst_i   - asynchronous active-high reset, clears every stage
//            i_data  - value entering the pipe
//            o_data  - value delayed by DEPTH cycles
// Revision : 1.0 - initial release
// ============================================================================
module decim_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         Clk_i,
    input  logic         Rst_i,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_data = i_data;
        end else begin : g_pipe
            logic [W-1:0] r_stage [DEPTH];

            always_ff @(posedge Clk_i or posedge Rst_i) begin
                if (Rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/decim_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : decim_ctrl_mc
// Purpose  : Multi-channel sequencer for a single-MAC decimating FIR.
//            Tracks interleaved sample writes, counts decimation phase per
//            frame and, on each output trigger, walks data/coefficient read
//            addresses through every tap of every channel.
// Ports    : Rst_i        - asynchronous active-high reset
//            Clk_i        - clock
//            DataNd_i     - new sample strobe (channels in order 0..N-1)
//            DataAddrWr_o - {wrCh, wrPtr} write address of current sample
//            DataAddr_o   - {rdCh, base-tap} read address
//            CoeffAddr_o  - tap index
//            StartAcc_o   - clear-and-load accumulator (tap 0 at MAC)
//            DataValid_o  - accumulator result valid, one cycle
//            DataCh_o     - channel of the current DataValid_o
//            Busy_o       - sequencer running
//            Overrun_o    - one-cycle pulse when a trigger is dropped
// Options  : DECIM_CTRL_OVERRUN_EN - queue one early trigger and report
//            overruns; when undefined early triggers are silently dropped.
// Revision : 1.0 - initial release
// ============================================================================
module decim_ctrl_mc
    import decim_pkg::*;
#(
    parameter int FilterLength = 16,
    parameter int DecimationK  = 2,
    parameter int Channels     = 1,
    parameter int AddrW        = 4,
    parameter int ChW          = 1,
    parameter int MacLat       = DecimDefaultMacLat
) (
    input  logic                 Rst_i,
    input  logic                 Clk_i,
    input  logic                 DataNd_i,
    output logic [ChW+AddrW-1:0] DataAddrWr_o,
    output logic [ChW+AddrW-1:0] DataAddr_o,
    output logic [AddrW-1:0]     CoeffAddr_o,
    output logic                 StartAcc_o,
    output logic                 DataValid_o,
    output logic [ChW-1:0]       DataCh_o,
    output logic                 Busy_o,
    output logic                 Overrun_o
);

    localparam int PhW = (DecimationK > 1) ? $clog2(DecimationK) : 1;
    localparam logic [ChW-1:0]   c_last_ch  = ChW'(Channels - 1);
    localparam logic [AddrW-1:0] c_last_tap = AddrW'(FilterLength - 1);
    localparam logic [PhW-1:0]   c_last_ph  = PhW'(DecimationK - 1);

    // ---------------- write side ----------------
    logic [ChW-1:0]   r_wr_ch;
    logic [AddrW-1:0] r_wr_ptr;
    logic [PhW-1:0]   r_phase;

    logic             w_wr_frame;
    logic             w_trig;
    logic [AddrW-1:0] w_wr_ptr_nxt;

    assign w_wr_frame   = DataNd_i && (r_wr_ch == c_last_ch);
    assign w_trig       = w_wr_frame && (r_phase == '0);
    assign w_wr_ptr_nxt = w_wr_frame ? (r_wr_ptr + 1'b1) : r_wr_ptr;

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_wr_ch  <= '0;
            r_wr_ptr <= '0;
            r_phase  <= '0;
        end else if (DataNd_i) begin
            if (r_wr_ch == c_last_ch) begin
                r_wr_ch  <= '0;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_phase  <= (r_phase == c_last_ph) ? '0 : (r_phase + 1'b1);
            end else begin
                r_wr_ch  <= r_wr_ch + 1'b1;
            end
        end
    end

    assign DataAddrWr_o = {r_wr_ch, r_wr_ptr};

    // ---------------- read sequencer ----------------
    decim_state_t         r_state;
    logic [AddrW-1:0]     r_tap;
    logic [ChW-1:0]       r_rd_ch;
    logic [AddrW-1:0]     r_base;
    logic [ChW+AddrW-1:0] r_data_addr;

    logic             w_last_tap;
    logic [AddrW-1:0] w_tap_nxt;
    logic [ChW-1:0]   w_rd_ch_nxt;
    logic [AddrW-1:0] w_wrap_nxt;
    logic             w_restart;
    logic [AddrW-1:0] w_restart_base;

    assign w_last_tap  = (r_tap == c_last_tap);
    assign w_tap_nxt   = r_tap + 1'b1;
    assign w_rd_ch_nxt = r_rd_ch + 1'b1;
    assign w_wrap_nxt  = AddrW'(decim_addr_wrap(32'(r_base), 32'(w_tap_nxt), AddrW));

`ifdef DECIM_CTRL_OVERRUN_EN
    logic             r_pend;
    logic [AddrW-1:0] r_pend_base;
    logic             r_overrun;
    logic             w_final;

    assign w_final = (r_state == ST_RUN) && w_last_tap && (r_rd_ch == c_last_ch);
    // The queued trigger is older than one arriving now, so it runs first.
    assign w_restart      = w_trig || r_pend;
    assign w_restart_base = r_pend ? r_pend_base : r_wr_ptr;
    assign Overrun_o      = r_overrun;
`else
    assign w_restart      = w_trig;
    assign w_restart_base = r_wr_ptr;
    assign Overrun_o      = 1'b0;
`endif

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_state     <= ST_IDLE;
            r_tap       <= '0;
            r_rd_ch     <= '0;
            r_base      <= '0;
            r_data_addr <= '0;
`ifdef DECIM_CTRL_OVERRUN_EN
            r_pend      <= 1'b0;
            r_pend_base <= '0;
            r_overrun   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tap   <= '0;
                    r_rd_ch <= '0;
                    if (w_trig) begin
                        r_state     <= ST_RUN;
                        r_base      <= r_wr_ptr;
                        r_data_addr <= {{ChW{1'b0}}, r_wr_ptr};
                    end else begin
                        // Track the write pointer so the idle address is current.
                        r_data_addr <= {{ChW{1'b0}}, w_wr_ptr_nxt};
                    end
                end
                ST_RUN: begin
                    if (w_last_tap) begin
                        r_tap <= '0;
                        if (r_rd_ch != c_last_ch) begin
                            r_rd_ch     <= w_rd_ch_nxt;
                            r_data_addr <= {w_rd_ch_nxt, r_base};
                        end else if (w_restart) begin
                            r_rd_ch     <= '0;
                            r_base      <= w_restart_base;
                            r_data_addr <= {{ChW{1'b0}}, w_restart_base};
                        end else begin
                            r_state     <= ST_IDLE;
                            r_rd_ch     <= '0;
                            r_data_addr <= {{ChW{1'b0}}, w_wr_ptr_nxt};
                        end
                    end else begin
                        r_tap       <= w_tap_nxt;
                        r_data_addr <= {r_rd_ch, w_wrap_nxt};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

`ifdef DECIM_CTRL_OVERRUN_EN
            r_overrun <= 1'b0;
            if ((r_state == ST_RUN) && w_trig) begin
                if (w_final) begin
                    // Pending slot drains into the restart and refills with
                    // this trigger; with no pending the trigger runs directly.
                    if (r_pend) begin
                        r_pend_base <= r_wr_ptr;
                    end
                end else if (r_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend      <= 1'b1;
                    r_pend_base <= r_wr_ptr;
                end
            end else if (w_final) begin
                r_pend <= 1'b0;
            end
`endif
        end
    end

    assign DataAddr_o  = r_data_addr;
    assign CoeffAddr_o = r_tap;
    assign Busy_o      = (r_state == ST_RUN);

    // ---------------- MAC alignment pipelines ----------------
    logic           w_start;
    logic           w_done;
    logic [ChW:0]   w_done_tag;

    assign w_start = (r_state == ST_RUN) && (r_tap == '0);
    assign w_done  = (r_state == ST_RUN) && w_last_tap;

    decim_delay_line #(
        .W     (1),
        .DEPTH (MacLat)
    ) u_start_dly (
        .Clk_i  (Clk_i),
        .Rst_i  (Rst_i),
        .i_data (w_start),
        .o_data (StartAcc_o)
    );

    decim_delay_line #(
        .W     (ChW + 1),
        .DEPTH (MacLat + 1)
    ) u_done_dly (
        .Clk_i  (Clk_i),
        .Rst_i  (Rst_i),
        .i_data ({w_done, r_rd_ch}),
        .o_data (w_done_tag)
    );

    assign DataValid_o = w_done_tag[ChW];
    assign DataCh_o    = w_done_tag[ChW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_decim_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_decim_ctrl_mc
// Purpose  : Scoreboard bench for decim_ctrl_mc (2 channels, K=2, L=4).
//            The stimulus process runs a frame-schedule reference model and
//            queues expected per-cycle read addresses and pipeline events;
//            the monitor process compares them against the DUT.
// Options  : DECIM_CTRL_OVERRUN_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decim_ctrl_mc;

    localparam int L     = 4;
    localparam int K     = 2;
    localparam int CH    = 2;
    localparam int AW    = 4;
    localparam int CW    = 1;
    localparam int ML    = 2;
    localparam int AMASK = (1 << AW) - 1;
`ifdef DECIM_CTRL_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic              Clk_i    = 1'b0;
    logic              Rst_i    = 1'b1;
    logic              DataNd_i = 1'b0;
    logic [CW+AW-1:0]  DataAddrWr_o;
    logic [CW+AW-1:0]  DataAddr_o;
    logic [AW-1:0]     CoeffAddr_o;
    logic              StartAcc_o;
    logic              DataValid_o;
    logic [CW-1:0]     DataCh_o;
    logic              Busy_o;
    logic              Overrun_o;

    decim_ctrl_mc #(
        .FilterLength (L),
        .DecimationK  (K),
        .Channels     (CH),
        .AddrW        (AW),
        .ChW          (CW),
        .MacLat       (ML)
    ) dut (
        .Rst_i        (Rst_i),
        .Clk_i        (Clk_i),
        .DataNd_i     (DataNd_i),
        .DataAddrWr_o (DataAddrWr_o),
        .DataAddr_o   (DataAddr_o),
        .CoeffAddr_o  (CoeffAddr_o),
        .StartAcc_o   (StartAcc_o),
        .DataValid_o  (DataValid_o),
        .DataCh_o     (DataCh_o),
        .Busy_o       (Busy_o),
        .Overrun_o    (Overrun_o)
    );

    always #5 Clk_i = ~Clk_i;

    int cyc = 0;
    always @(posedge Clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct { int c; int addr; int coeff; } rd_t;
    typedef struct { int c; int ch; }              ev_t;
    typedef struct { int c; int addr; }            wr_t;

    rd_t q_rd[$];
    int  q_start[$];
    ev_t q_val[$];
    int  q_ovr[$];
    wr_t q_wr[$];

    // Reference model state: write counters and the schedule of frames.
    int m_wrch, m_wrptr, m_phase;
    int m_final;   // cycle index of the last RUN cycle of the current frame
    bit m_pend;
    int m_pbase;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q_rd.delete(); q_start.delete(); q_val.delete(); q_ovr.delete(); q_wr.delete();
        m_wrch = 0; m_wrptr = 0; m_phase = 0;
        m_final = -1; m_pend = 1'b0; m_pbase = 0;
    endtask

    // A frame starting at cycle s reads every tap of every channel in order.
    task automatic start_frame(input int s, input int b);
        for (int ch = 0; ch < CH; ch++) begin
            for (int tap = 0; tap < L; tap++) begin
                q_rd.push_back('{s + ch*L + tap, (ch << AW) | ((b - tap) & AMASK), tap});
            end
            q_start.push_back(s + ch*L + ML);
            q_val.push_back('{s + ch*L + (L - 1) + ML + 1, ch});
        end
        m_final = s + CH*L - 1;
    endtask

    task automatic step(input bit nd, input bit rst);
        bit t;
        int c;
        @(posedge Clk_i);
        #1;
        c        = cyc;
        Rst_i    = rst;
        DataNd_i = nd & ~rst;
        if (rst) begin
            model_reset();
            return;
        end
        q_wr.push_back('{c, (m_wrch << AW) | m_wrptr});
        t = nd && (m_wrch == CH-1) && (m_phase == 0);
        if (m_final < c) begin
            if (t) start_frame(c + 1, m_wrptr);
        end else if (m_final == c) begin
            if (OVR && m_pend) begin
                start_frame(c + 1, m_pbase);
                m_pend  = t;
                m_pbase = m_wrptr;
            end else if (t) begin
                start_frame(c + 1, m_wrptr);
            end
        end else if (OVR && t) begin
            if (m_pend) q_ovr.push_back(c + 1);
            else begin
                m_pend  = 1'b1;
                m_pbase = m_wrptr;
            end
        end
        if (nd) begin
            if (m_wrch == CH-1) begin
                m_wrch  = 0;
                m_wrptr = (m_wrptr + 1) & AMASK;
                m_phase = (m_phase + 1) % K;
            end else begin
                m_wrch++;
            end
        end
    endtask

    // Monitor: compares DUT outputs with the queued expectations each cycle.
    always @(negedge Clk_i) begin : p_mon
        wr_t w;
        rd_t r;
        ev_t v;
        bit  eb;
        int  idle_ptr;
        if (Rst_i) begin
            chk("rst_wr_addr",  int'(DataAddrWr_o), 0);
            chk("rst_rd_addr",  int'(DataAddr_o),   0);
            chk("rst_coeff",    int'(CoeffAddr_o),  0);
            chk("rst_start",    int'(StartAcc_o),   0);
            chk("rst_valid",    int'(DataValid_o),  0);
            chk("rst_ch",       int'(DataCh_o),     0);
            chk("rst_busy",     int'(Busy_o),       0);
            chk("rst_overrun",  int'(Overrun_o),    0);
        end else begin
            idle_ptr = 0;
            if (q_wr.size() > 0 && q_wr[0].c == cyc) begin
                w = q_wr.pop_front();
                chk("wr_addr", int'(DataAddrWr_o), w.addr);
                idle_ptr = w.addr & AMASK;
            end

            eb = (q_rd.size() > 0) && (q_rd[0].c == cyc);
            chk("busy", int'(Busy_o), int'(eb));
            if (eb) begin
                r = q_rd.pop_front();
                chk("rd_addr", int'(DataAddr_o),  r.addr);
                chk("coeff",   int'(CoeffAddr_o), r.coeff);
            end else begin
                chk("idle_rd_addr", int'(DataAddr_o),  idle_ptr);
                chk("idle_coeff",   int'(CoeffAddr_o), 0);
            end

            eb = (q_start.size() > 0) && (q_start[0] == cyc);
            chk("start_acc", int'(StartAcc_o), int'(eb));
            if (eb) void'(q_start.pop_front());

            eb = (q_val.size() > 0) && (q_val[0].c == cyc);
            chk("data_valid", int'(DataValid_o), int'(eb));
            if (eb) begin
                v = q_val.pop_front();
                chk("data_ch", int'(DataCh_o), v.ch);
            end

            eb = (q_ovr.size() > 0) && (q_ovr[0] == cyc);
            chk("overrun", int'(Overrun_o), int'(eb));
            if (eb) void'(q_ovr.pop_front());
        end
    end

    initial begin : p_stim
        int guard;
        model_reset();
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Sparse strobes: a single frame with base 0 (wraps to 15, 14, 13).
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            repeat (5) step(1'b0, 1'b0);
        end
        repeat (20) step(1'b0, 1'b0);

        // Strobe every 2 cycles: each trigger lands on the final RUN cycle.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        repeat (20) step(1'b0, 1'b0);

        // Strobe every cycle: triggers outpace the sequencer.
        repeat (16) step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);

        // Random strobe density.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 30, 1'b0);
        end
        repeat (30) step(1'b0, 1'b0);

        // Reset in the middle of a frame, then a fresh trigger.
        guard = 0;
        while (m_final < cyc && guard < 16) begin
            step(1'b1, 1'b0);
            guard++;
        end
        repeat (5) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        repeat (15) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (25) step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
